// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS32 control path.
// CONTROL_ADDI_EN adds the ADDI_EX/ADDI_WB states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ASB_REGB = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
`ifdef CONTROL_ADDI_EN
    ,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/control_multiciclo_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, control lines out.
interface control_multiciclo_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       illegal;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
    output MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst,
    output ALUOp, ALUSrcB, PCSource, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
    input  MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst,
    input  ALUOp, ALUSrcB, PCSource, illegal
  );
endinterface

// File: rtl/control_multiciclo_salidas.sv
// Combinational state -> control decoder; en low forces every line to 0.
// CONTROL_ADDI_EN adds the addi execute/write-back decodes.
module control_multiciclo_salidas
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   en,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (en) begin
      unique case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = ASB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = ASB_IMM2;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ASB_IMM;
        end
        S_MEMRD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ASB_REGB;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RTYPE_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCS_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_JUMP;
        end
`ifdef CONTROL_ADDI_EN
        S_ADDI_EX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ASB_IMM;
        end
        S_ADDI_WB: begin
          ctrl.reg_write = 1'b1;
        end
`endif
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS32 main control FSM: state register and next-state logic.
// CONTROL_ADDI_EN enables addi (opcode 001000); otherwise it is illegal.
module control_multiciclo
  import mips_ctrl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  control_multiciclo_if.master bus
);

  state_t state;
  state_t state_nx;
  logic   bad_op;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = S_FETCH;
    bad_op   = 1'b0;
    unique case (state)
      S_FETCH:  state_nx = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_EXEC;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_J:         state_nx = S_JUMP;
`ifdef CONTROL_ADDI_EN
          OP_ADDI:      state_nx = S_ADDI_EX;
`endif
          default:      bad_op   = 1'b1;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW)      state_nx = S_MEMRD;
        else if (bus.opcode == OP_SW) state_nx = S_MEMWR;
      end
      S_MEMRD:    state_nx = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_nx = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:     state_nx = S_RTYPE_WB;
`ifdef CONTROL_ADDI_EN
      S_ADDI_EX:  state_nx = S_ADDI_WB;
`endif
      default:    state_nx = S_FETCH;
    endcase
  end

  control_multiciclo_salidas u_salidas (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .en        (rst_n),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.illegal     = rst_n & bad_op;

endmodule
